// File: rtl/counter_pkg.sv
// Shared definitions for the counter/flip-flop library: FSM state type and
// the default counter width used by both the up- and down-counters.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cnt_state_e;

endpackage : counter_pkg

// File: rtl/sync_down_counter.sv
// Synchronous loadable down-counter with optional auto-reload and a registered
// one-cycle terminal-count pulse. Every output comes straight from a flop.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_state_e       state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic [WIDTH-1:0] reload_r;
    logic             tc_r;
    logic             busy_r;
    logic             done_r;

    cnt_state_e       state_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] reload_nxt_s;
    logic             tc_nxt_s;
    logic [WIDTH-1:0] q_dec_s;

    // Decrementer; only used when q_r > 1, so it can never wrap below zero.
    always_comb begin
        q_dec_s = q_r - ONE_C;
    end

    // Next-state and next-count selection: load beats enable beats hold.
    always_comb begin
        state_nxt_s  = state_r;
        q_nxt_s      = q_r;
        reload_nxt_s = reload_r;
        tc_nxt_s     = 1'b0;
        if (load) begin
            q_nxt_s      = load_value;
            reload_nxt_s = load_value;
            if (load_value != ZERO_C) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_DONE;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (enable) begin
                        if (q_r > ONE_C) begin
                            q_nxt_s = q_dec_s;
                        end else if (q_r == ONE_C) begin
                            q_nxt_s  = ZERO_C;
                            tc_nxt_s = 1'b1;
                            if (auto_reload) begin
                                state_nxt_s = ST_RUN;
                            end else begin
                                state_nxt_s = ST_DONE;
                            end
                        end else begin
                            // Sitting at zero: the reload step costs one enabled cycle.
                            if (auto_reload) begin
                                q_nxt_s = reload_r;
                            end else begin
                                state_nxt_s = ST_DONE;
                            end
                        end
                    end else begin
                        q_nxt_s = q_r;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    q_nxt_s = q_r;
                end
                default: begin
                    // Illegal encoding: fall back to a safe, quiet state.
                    state_nxt_s = ST_IDLE;
                    q_nxt_s     = ZERO_C;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            q_r      <= ZERO_C;
            qb_r     <= ~ZERO_C;
            reload_r <= ZERO_C;
            tc_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            q_r      <= q_nxt_s;
            qb_r     <= ~q_nxt_s;
            reload_r <= reload_nxt_s;
            tc_r     <= tc_nxt_s;
            busy_r   <= (state_nxt_s == ST_RUN);
            done_r   <= (state_nxt_s == ST_DONE);
        end
    end

    assign q    = q_r;
    assign qb   = qb_r;
    assign tc   = tc_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (WIDTH=4): directed scenarios then
// random traffic, all compared against a behavioural countdown model.
module tb_sync_down_counter;

    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       auto_reload;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
    logic       busy;
    logic       done;

    int n_asserts = 0;
    int n_fail    = 0;

    // Model: mode 0 = idle, 1 = counting, 2 = finished.
    int m_q      = 0;
    int m_reload = 0;
    int m_mode   = 0;
    int m_tc     = 0;

    sync_down_counter #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .qb          (qb),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic predict();
        if (reset) begin
            m_mode = 0; m_q = 0; m_reload = 0; m_tc = 0;
        end else if (load) begin
            m_q = load_value; m_reload = load_value; m_tc = 0;
            m_mode = (load_value != 0) ? 1 : 2;
        end else if (m_mode == 1 && enable) begin
            if (m_q == 0) begin
                m_tc = 0;
                if (auto_reload) m_q = m_reload;
                else m_mode = 2;
            end else begin
                m_q = m_q - 1;
                m_tc = (m_q == 0) ? 1 : 0;
                if (m_q == 0 && !auto_reload) m_mode = 2;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic step(input string tag);
        predict();
        @(posedge clock);
        #1;
        chk({tag, " q"}, 32'(q), 32'(m_q));
        chk({tag, " qb"}, 32'(qb), 32'((~m_q) & 15));
        chk({tag, " tc"}, 32'(tc), 32'(m_tc));
        chk({tag, " busy"}, 32'(busy), 32'(m_mode == 1));
        chk({tag, " done"}, 32'(done), 32'(m_mode == 2));
    endtask

    initial begin
        int tc_seen;
        int steps;
        reset = 1'b1; load = 1'b1; load_value = 4'd9; enable = 1'b0; auto_reload = 1'b0;
        #2;
        step("reset0");
        step("reset1");
        chk("reset_q_const", 32'(q), 32'd0);
        chk("reset_qb_const", 32'(qb), 32'd15);

        reset = 1'b0; load = 1'b0; enable = 1'b1;
        step("idle_enable");

        // One-shot count from 3.
        load = 1'b1; load_value = 4'd3; auto_reload = 1'b0; enable = 1'b0;
        step("oneshot_load");
        chk("oneshot_load_const", 32'(q), 32'd3);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) step("oneshot");
        chk("oneshot_done_const", 32'(done), 32'd1);

        // Auto-reload from 2: period of 3 enabled cycles.
        load = 1'b1; load_value = 4'd2; auto_reload = 1'b1; enable = 1'b1;
        step("auto_load");
        load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step("auto");
            tc_seen += int'(tc);
        end
        chk("auto_tc_count", 32'(tc_seen), 32'd2);

        // Enable gaps, then reload over a running count at q==1.
        load = 1'b1; load_value = 4'd5; auto_reload = 1'b0; enable = 1'b0;
        step("gap_load");
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable = logic'(i % 2);
            step("gap");
        end
        enable = 1'b1;
        step("gap_to1");
        chk("gap_q1_const", 32'(q), 32'd1);
        load = 1'b1; load_value = 4'd7;
        step("load_over");
        chk("load_over_q_const", 32'(q), 32'd7);
        chk("load_over_tc_const", 32'(tc), 32'd0);

        // Load zero goes straight to done with no pulse.
        load_value = 4'd0;
        step("load0");
        chk("load0_done_const", 32'(done), 32'd1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) step("load0_hold");

        // Full-range count: 15 decrements before tc.
        load = 1'b1; load_value = 4'd15;
        step("load15");
        load = 1'b0;
        steps = 0;
        tc_seen = 0;
        while (tc_seen == 0 && steps < 20) begin
            step("count15");
            steps++;
            tc_seen = int'(tc);
        end
        chk("count15_steps", 32'(steps), 32'd15);

        // Reset in the middle of a count.
        load = 1'b1; load_value = 4'd6;
        step("mid_load");
        load = 1'b0;
        step("mid_dec");
        step("mid_dec");
        chk("mid_q4_const", 32'(q), 32'd4);
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        step("mid_after");
        chk("mid_after_q_const", 32'(q), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            load        = ($urandom_range(0, 9) == 0);
            load_value  = 4'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_sync_down_counter
